// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - six-digit multiplexed 7-segment scan driver
//
// Drives one common-cathode digit at a time from a frame-consistent shadow
// copy of the six BCD clock digits, with per-digit blinking, hour-tens
// leading-zero blanking, flashing separator dots and a dash for invalid BCD.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   din        six BCD digits, din[4k+3:4k] is digit k (5 = hour tens)
//   blink_mask bit k=1 blinks digit k
//   blank_lz   1 blanks digit 5 when it is zero
//   dp_en      1 enables the flashing hour:min and min:sec dots
//   seg        {dp,g,f,e,d,c,b,a}, active-high, registered
//   sel        one-cold active-low digit enables, registered

module seg_scan_display #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] din,
    input  logic [5:0]  blink_mask,
    input  logic        blank_lz,
    input  logic        dp_en,
    output logic [7:0]  seg,
    output logic [5:0]  sel
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       idx;
    logic [23:0]      shadow;
    logic [BLK_W-1:0] blink_cnt;
    logic             blink_phase;

    logic             tick;
    logic [3:0]       digit;
    logic [6:0]       seg_dec;
    logic             blank;
    logic             dp;
    logic [7:0]       seg_nxt;
    logic [5:0]       sel_nxt;

    assign tick = (div_cnt == DIV_LAST);

    always_comb begin
        digit = shadow[{idx, 2'b00} +: 4];

        case (digit)
            4'd0:    seg_dec = 7'h3F;
            4'd1:    seg_dec = 7'h06;
            4'd2:    seg_dec = 7'h5B;
            4'd3:    seg_dec = 7'h4F;
            4'd4:    seg_dec = 7'h66;
            4'd5:    seg_dec = 7'h6D;
            4'd6:    seg_dec = 7'h7D;
            4'd7:    seg_dec = 7'h07;
            4'd8:    seg_dec = 7'h7F;
            4'd9:    seg_dec = 7'h6F;
            default: seg_dec = 7'h40;   // invalid BCD shows a dash
        endcase

        // Blink-off wins over everything, including the invalid-BCD dash.
        blank = (blink_mask[idx] & blink_phase)
              | (blank_lz & (idx == 3'd5) & (digit == 4'd0));

        // Dots sit to the right of hour ones (4) and minute ones (2); they
        // flash with the blink phase but ignore digit blanking.
        dp = dp_en & ~blink_phase & ((idx == 3'd4) | (idx == 3'd2));

        seg_nxt = {dp, blank ? 7'h00 : seg_dec};
        sel_nxt = ~(6'b000001 << idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            idx         <= 3'd0;
            shadow      <= 24'h0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            seg         <= 8'h00;
            sel         <= 6'b111111;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;

            if (tick) begin
                if (idx == 3'd5) begin
                    idx    <= 3'd0;
                    // Sample once per frame so all six digits agree.
                    shadow <= din;
                end else begin
                    idx <= idx + 3'd1;
                end
            end

            if (blink_cnt == BLK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            seg <= seg_nxt;
            sel <= sel_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// tb/tb_seg_scan_display.sv - self-checking bench for seg_scan_display

module tb_seg_scan_display;

    localparam int SD    = 4;
    localparam int BD    = 8;
    localparam int FRAME = 6 * SD;

    logic        clk;
    logic        rst_n;
    logic [23:0] din;
    logic [5:0]  blink_mask;
    logic        blank_lz;
    logic        dp_en;
    logic [7:0]  seg;
    logic [5:0]  sel;

    int checks;
    int errors;
    int edge_n;
    logic [23:0] shadow_exp;
    logic [13:0] exp_q[$];

    seg_scan_display #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .blink_mask (blink_mask),
        .blank_lz   (blank_lz),
        .dp_en      (dp_en),
        .seg        (seg),
        .sel        (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // Expected {seg,sel} right after edge n (n=1 is the first edge after reset release).
    function automatic logic [13:0] expect_out(input int n);
        int         ix;
        int         ph;
        logic [3:0] v;
        logic [6:0] s;
        logic       dp;
        logic [5:0] one;
        ix  = ((n - 1) / SD) % 6;
        ph  = ((n - 1) / BD) % 2;
        v   = shadow_exp[4*ix +: 4];
        s   = seg_of(v);
        if ((blink_mask[ix] && ph == 1) || (blank_lz && ix == 5 && v == 4'd0))
            s = 7'h00;
        dp  = dp_en && (ph == 0) && (ix == 4 || ix == 2);
        one = 6'b000001;
        return {dp, s, ~(one << ix)};
    endfunction

    // Advance one edge; the frame sample happens on every FRAME-th edge.
    task automatic tick_clk();
        @(posedge clk);
        #1;
        edge_n++;
        if (edge_n % FRAME == 0)
            shadow_exp = din;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n      = 1'b1;
        edge_n     = 0;
        shadow_exp = 24'h0;
    endtask

    task automatic test_reset();
        din = 24'h000000; blink_mask = 6'b0; blank_lz = 1'b0; dp_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (seg !== 8'h00) begin errors++; $display("FAIL reset_seg got %h want 00", seg); end
        checks++;
        if (sel !== 6'b111111) begin errors++; $display("FAIL reset_sel got %b want 111111", sel); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({seg, sel} !== 14'h003F) begin
            errors++; $display("FAIL reset_hold got seg=%h sel=%b want 00/111111", seg, sel);
        end
        @(negedge clk);
        rst_n = 1'b1; edge_n = 0; shadow_exp = 24'h0;
        tick_clk();
        checks++;
        if (sel !== 6'b111110 || seg !== 8'h3F) begin
            errors++; $display("FAIL reset_first_edge got seg=%h sel=%b want 3f/111110", seg, sel);
        end
    endtask

    task automatic test_scan_order();
        logic [13:0] e;
        din = 24'h123456; blink_mask = 6'b0; blank_lz = 1'b0; dp_en = 1'b0;
        apply_reset();
        for (int i = 0; i < 2 * FRAME; i++) begin
            exp_q.push_back(expect_out(edge_n + 1));
            tick_clk();
            e = exp_q.pop_front();
            checks++;
            if ({seg, sel} !== e) begin
                errors++;
                $display("FAIL scan_order edge %0d got seg=%h sel=%b want seg=%h sel=%b",
                         edge_n, seg, sel, e[13:6], e[5:0]);
            end
            checks++;
            if ($countones(~sel) != 1) begin
                errors++; $display("FAIL one_cold edge %0d got sel=%b want one low bit", edge_n, sel);
            end
        end
        // Last edge of second frame: digit 5 of 123456 is '1'.
        checks++;
        if (seg !== 8'h06 || sel !== 6'b011111) begin
            errors++; $display("FAIL scan_last_digit got seg=%h sel=%b want 06/011111", seg, sel);
        end
    endtask

    task automatic test_frame_consistency();
        logic [13:0] e;
        din = 24'h123459; blink_mask = 6'b0; blank_lz = 1'b0; dp_en = 1'b0;
        apply_reset();
        for (int i = 0; i < 3 * FRAME; i++) begin
            // Change din while the second frame is scanning digit 2.
            if (edge_n == FRAME + 2 * SD + 1)
                din = 24'h123500;
            exp_q.push_back(expect_out(edge_n + 1));
            tick_clk();
            e = exp_q.pop_front();
            checks++;
            if ({seg, sel} !== e) begin
                errors++;
                $display("FAIL frame_consistency edge %0d got seg=%h sel=%b want seg=%h sel=%b",
                         edge_n, seg, sel, e[13:6], e[5:0]);
            end
        end
    endtask

    task automatic test_blink();
        logic [13:0] e;
        din = 24'h235959; blink_mask = 6'b001100; blank_lz = 1'b0; dp_en = 1'b0;
        apply_reset();
        for (int i = 0; i < 3 * FRAME; i++) begin
            exp_q.push_back(expect_out(edge_n + 1));
            tick_clk();
            e = exp_q.pop_front();
            checks++;
            if ({seg, sel} !== e) begin
                errors++;
                $display("FAIL blink edge %0d got seg=%h sel=%b want seg=%h sel=%b",
                         edge_n, seg, sel, e[13:6], e[5:0]);
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [13:0] e;
        din = 24'h09A000; blink_mask = 6'b0; blank_lz = 1'b1; dp_en = 1'b0;
        apply_reset();
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (i == 2 * FRAME)
                blank_lz = 1'b0;
            exp_q.push_back(expect_out(edge_n + 1));
            tick_clk();
            e = exp_q.pop_front();
            checks++;
            if ({seg, sel} !== e) begin
                errors++;
                $display("FAIL leading_zero edge %0d got seg=%h sel=%b want seg=%h sel=%b",
                         edge_n, seg, sel, e[13:6], e[5:0]);
            end
        end
    endtask

    task automatic test_separators();
        logic [13:0] e;
        din = 24'h121530; blink_mask = 6'b110000; blank_lz = 1'b0; dp_en = 1'b1;
        apply_reset();
        for (int i = 0; i < 3 * FRAME; i++) begin
            exp_q.push_back(expect_out(edge_n + 1));
            tick_clk();
            e = exp_q.pop_front();
            checks++;
            if ({seg, sel} !== e) begin
                errors++;
                $display("FAIL separators edge %0d got seg=%h sel=%b want seg=%h sel=%b",
                         edge_n, seg, sel, e[13:6], e[5:0]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [13:0] e;
        din = 24'h654321; blink_mask = 6'b0; blank_lz = 1'b0; dp_en = 1'b1;
        apply_reset();
        for (int i = 0; i < FRAME + 3 * SD + 2; i++)
            tick_clk();
        checks++;
        if (sel !== 6'b110111) begin
            errors++; $display("FAIL mid_frame_precondition got sel=%b want 110111", sel);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (seg !== 8'h00 || sel !== 6'b111111) begin
            errors++; $display("FAIL mid_frame_async got seg=%h sel=%b want 00/111111", seg, sel);
        end
        @(negedge clk);
        rst_n = 1'b1; edge_n = 0; shadow_exp = 24'h0;
        for (int i = 0; i < FRAME + SD; i++) begin
            exp_q.push_back(expect_out(edge_n + 1));
            tick_clk();
            e = exp_q.pop_front();
            checks++;
            if ({seg, sel} !== e) begin
                errors++;
                $display("FAIL mid_frame_restart edge %0d got seg=%h sel=%b want seg=%h sel=%b",
                         edge_n, seg, sel, e[13:6], e[5:0]);
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0; edge_n = 0; shadow_exp = 24'h0;
        rst_n = 1'b0;
        din = 24'h0; blink_mask = 6'b0; blank_lz = 1'b0; dp_en = 1'b0;
        test_reset();
        test_scan_order();
        test_frame_consistency();
        test_blink();
        test_leading_zero();
        test_separators();
        test_reset_mid_frame();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Multiplexed six-digit 7-segment scan driver for the multifunction digital clock. It reads the six BCD digits produced by the hour, minute and second counter chain and time-division drives one common-cathode display digit at a time. It also provides frame-consistent sampling, blinking of the digits under adjustment, leading-zero blanking, colon flashing and an invalid-BCD indication. It sits between the counter chain and the board's segment and digit-select pins.

## Interface
- SCAN_DIV, 50000: clk cycles each digit is driven (dwell); must be ≥2.
- BLINK_DIV, 25000000: clk cycles per blink half-period.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  24  BCD digits. din[4k+3:4k] is digit k: k=5 hour tens, 4 hour ones, 3 min tens, 2 min ones, 1 sec tens, 0 sec ones.
- blink_mask  input  6  bit k=1 makes digit k blink (for example 6'b001100 while adjusting minutes).
- blank_lz  input  1  1 blanks digit 5 when its value is 0.
- dp_en  input  1  1 enables the flashing separator dots.
- seg  output  8  {dp,g,f,e,d,c,b,a}, active-high.
- sel  output  6  digit enables, active-low, one-cold; sel[k] drives digit k.

## Operation
- Dwell counter div_cnt runs 0..SCAN_DIV-1 and wraps to 0. tick = (div_cnt == SCAN_DIV-1).
- Scan index idx runs 0..5. On tick it advances by 1, and 5 wraps to 0.
- Shadow register: on tick with idx==5, shadow <= din at the same edge that idx goes to 0. All six digits of a frame therefore come from one sample. din changes mid-frame never tear the display.
- Blink counter runs 0..BLINK_DIV-1. At the terminal count blink_phase toggles and the counter wraps. It runs independently of the scan.
- Digit value: v = shadow[4*idx+3:4*idx].
- Segment decode, seg[6:0]:
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F.
  - 10..15 → 40 (dash, g only).
- Blank conditions force seg[6:0]=0 while sel[idx] stays asserted. A digit is blanked when either:
  - blink_mask[idx]==1 and blink_phase==1, or
  - blank_lz==1, idx==5 and v==0.
- Blink blanking takes priority. Invalid BCD on a blinked digit in the off phase shows blank.
- seg[7] (dp) = dp_en & ~blink_phase & (idx==4 | idx==2), giving the hour:min and min:sec separators. dp is unaffected by digit blanking.
- seg and sel are registered. They are decoded from the current idx, shadow, blink_phase and inputs.
- blink_mask, blank_lz and dp_en are sampled live, not shadowed.
- Reset values:
  - seg=8'h00, sel=6'b111111.
  - idx=0, div_cnt=0, shadow=24'h0.
  - blink counter 0, blink_phase=0.
- Reset asserted mid-frame returns all of the above immediately and asynchronously. No partial digit is held.

## Timing
- seg/sel lag idx by exactly one clk.
- First rising edge after rst_n deasserts: sel=6'b111110 and seg shows shadow digit 0. That is 8'h3F, since shadow=0; with dp_en it remains 8'h3F because dp is not lit on digit 0.
- Each digit is driven for exactly SCAN_DIV cycles.
- One frame is 6*SCAN_DIV cycles.
- A new din value first appears at the digit-0 slot after the next frame boundary. Worst-case latency is 6*SCAN_DIV+1 cycles.
- Blink period is 2*BLINK_DIV cycles. blink_phase=0 (visible) for the first BLINK_DIV cycles after reset.
- Exactly one sel bit is low at all times after the first post-reset edge. Two bits are never low together.
- No handshake is used. din must be stable only at the sampling edge; the counter chain is synchronous to clk, so it is.

## Test plan
- Scan order:
  - Stimulus: SCAN_DIV=4, BLINK_DIV=8, din=24'h123456, blink_mask=0, blank_lz=0, dp_en=0. Run 2 frames.
  - First frame: digit 0 shows 3F, the others 3F.
  - Second frame: sel steps 111110, 111101, …, 011111, each for 4 cycles. seg shows 7D(6), 6D(5), 66(4), 4F(3), 5B(2), 06(1).
- Frame consistency: change din from 24'h123459 to 24'h123500 while idx=2. The current frame shows no mixed digits. The next frame shows 3F,3F,6D,4F,5B,06.
- Blink: blink_mask=6'b001100, din=24'h235959. Digits 2 and 3 show 6F/6D for 8 cycles, then 00 for 8 cycles, alternating. Other digits are unaffected and sel is unchanged.
- Leading zero and invalid:
  - din=24'h09A000, blank_lz=1: digit 5 seg=00, digit 4 shows 6F, digit 3 shows 40.
  - With blank_lz=0: digit 5 shows 3F.
- Separators: dp_en=1. seg[7]=1 only in the idx 4 and 2 slots while blink_phase=0, and 0 in the phase-1 half.
- Reset mid-frame: assert rst_n=0 at idx=3. seg=00 and sel=111111 immediately. After release, the first edge gives sel=111110, seg=3F, and the scan restarts from digit 0.
